center_derivative_stream: RTL and testbench
===========================================

Name: center_derivative_stream

Overview:
Parametrised streaming central-difference differentiator. It is the successor to center_derivative.
- Computes d[n] = x[n] - x[n-2*STEP], optionally halved, centred on sample x[n-STEP].
- Adds a valid handshake, programmable stencil half-width, signed output with a width rule, a warm-up phase and a history flush.
- Sits between the sample source and downstream edge/slope detection logic.

Parameters:
- DATA_W, 8: width of the unsigned input sample.
- STEP, 1: stencil half-width h (>=1). The delay line holds 2*STEP samples.
- OUT_W, DATA_W+1: width of the signed two's-complement output (>=2).

Ports:
- clk  in  1: rising-edge clock.
- rst  in  1: asynchronous, active-high reset.
- in_valid  in  1: the in_data sample is accepted this cycle.
- in_data  in  DATA_W: unsigned input sample.
- halve  in  1: mode, sampled together with in_valid. 0 gives d; 1 gives d>>>1 (floor).
- flush  in  1: synchronous clear of history and warm-up state.
- out_valid  out  1: one-cycle strobe; out_data is new.
- out_data  out  OUT_W: signed derivative result.
- primed  out  1: high when the delay line is full (RUN state).

Behaviour:
- Reset (async, immediate): delay line = 0, fill count = 0, state FILL, out_valid = 0, out_data = 0, primed = 0.
- Delay line: shifts only on an accepted sample (in_valid=1, flush=0). Cycles with in_valid=0 are bubbles: no shift, no output, all state held.
- State FILL: the fill count increments on each accepted sample. On the accept that brings the count to 2*STEP, go to RUN. No output is produced in FILL.
- State RUN: every accepted sample produces a result.
  - out_valid=1 on the next clock edge (latency 1 cycle, registered).
  - The result uses the new sample and the oldest stored sample, before the shift.
- out_valid is a single-cycle strobe per result. out_data holds its last value when out_valid=0.
- Arithmetic:
  - Both operands are zero-extended to DATA_W+1 bits, then subtracted.
  - The range is [-(2^DATA_W-1), +(2^DATA_W-1)].
  - halve=1 applies an arithmetic right shift, so it rounds toward -inf (e.g. -3 gives -2).
  - The result is sign-extended to OUT_W, or reduced to OUT_W per the Optional Feature.
- primed = (state == RUN), registered.
- flush=1: at the next edge, delay line = 0, count = 0, state FILL, primed = 0, out_valid = 0.
  - flush together with in_valid: flush wins and the sample is discarded.
- Reset asserted mid-stream: all state is cleared at once. Any pending out_valid strobe is suppressed. After reset release, a full refill of 2*STEP samples is required.
- The fill count saturates at 2*STEP and never wraps.

Optional Feature:
- Macro: CENTER_DERIVATIVE_SATURATE_EN.
- Defined: when the result does not fit OUT_W, clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: keep the OUT_W LSBs (two's-complement wrap).
- The feature has no effect when OUT_W >= DATA_W+1.

Decomposition:
- Package center_derivative_pkg holds:
  - state enum {FILL, RUN};
  - the localparam for delay depth (2*STEP) and the count width ($clog2(2*STEP+1));
  - the pure function that saturates or truncates a DATA_W+1 signed value to OUT_W.
- Sub-module sample_delay_line (DEPTH, W): shift register with shift-enable and synchronous clear, exposing the oldest tap. The top level contains the FSM, subtractor, shifter and output register.

Test Plan:
All scenarios use DATA_W=8, STEP=1 unless stated.
1. Reset, then samples 10,20,40,70 with halve=0 on consecutive cycles:
   - no out_valid for the first two samples;
   - primed rises after the 2nd sample;
   - outputs 30 then 50, each one cycle after its sample.
2. halve=1:
   - samples 0,9,3 give output 1;
   - samples 255,9,0 give -128 ((-255)>>>1, floor);
   - samples 0,9,255 give 127.
3. Bubbles: samples 5,_,_,8,_,20 (underscore = in_valid low):
   - exactly one out_valid, with value 15;
   - no strobes in bubble cycles;
   - out_data holds 15 afterwards.
4. Flush:
   - in RUN, assert flush together with in_valid=1, in_data=99: sample discarded, primed drops.
   - Next samples 1,2: no output.
   - Next sample 7: output 6.
5. STEP=2, samples 0,1,2,3,50:
   - first out_valid on the 5th sample, value 50;
   - primed rises after the 4th sample.
6. OUT_W=6, samples 0,x,100 and then 100,x,0:
   - with CENTER_DERIVATIVE_SATURATE_EN: outputs 31 and -32;
   - without it: outputs -28 and 28.
   - Additionally, async rst pulsed between cycles clears out_valid, out_data and primed immediately.

Source files
------------

// File: rtl/center_derivative_pkg.sv
`default_nettype none
// ==========================================================================
// center_derivative_pkg : shared types, sizing helpers and output reducer
// Revision: 1.0
// ==========================================================================
package center_derivative_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_STEP = 1;

    function automatic int delay_depth(input int step);
        return 2 * step;
    endfunction

    function automatic int count_width(input int step);
        return $clog2(2 * step + 1);
    endfunction

    localparam int DEFAULT_DEPTH = delay_depth(DEFAULT_STEP);
    localparam int DEFAULT_CNT_W = count_width(DEFAULT_STEP);

    // Reduce a sign-extended result to out_w bits; caller keeps the LSBs.
    function automatic logic signed [31:0] fit_out(input logic signed [31:0] v,
                                                   input int out_w);
`ifdef CENTER_DERIVATIVE_SATURATE_EN
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return (v <<< (32 - out_w)) >>> (32 - out_w);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/center_derivative_stream_delay.sv
`default_nettype none
// ==========================================================================
// sample_delay_line : enable-gated shift register, sync clear, oldest tap out
// Revision: 1.0
// ==========================================================================
module sample_delay_line #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] oldest
);

    logic [W-1:0] taps [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps[0] <= '0;
        end else if (clear) begin
            taps[0] <= '0;
        end else if (shift_en) begin
            taps[0] <= din;
        end
    end

    for (genvar i = 1; i < DEPTH; i++) begin : g_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                taps[i] <= '0;
            end else if (clear) begin
                taps[i] <= '0;
            end else if (shift_en) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign oldest = taps[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/center_derivative_stream.sv
`default_nettype none
// ==========================================================================
// center_derivative_stream : streaming d[n] = x[n] - x[n-2*STEP], opt. halved
// Option macro: CENTER_DERIVATIVE_SATURATE_EN (clamp instead of wrap). Rev 1.0
// ==========================================================================
module center_derivative_stream
    import center_derivative_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int STEP   = 1,
    parameter int OUT_W  = DATA_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    halve,
    input  logic                    flush,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    primed
);

    localparam int DEPTH = delay_depth(STEP);
    localparam int CNT_W = count_width(STEP);

    logic                    accept;
    logic                    emit;
    logic                    last_fill;
    logic [DATA_W-1:0]       oldest;
    logic [CNT_W-1:0]        fill_count;
    logic signed [DATA_W:0]  diff;
    logic signed [DATA_W:0]  scaled;
    state_t                  state;
    state_t                  state_next;

    // flush outranks a coincident sample
    assign accept    = in_valid & ~flush;
    assign last_fill = (fill_count == CNT_W'(DEPTH - 1));

    sample_delay_line #(
        .DEPTH (DEPTH),
        .W     (DATA_W)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .clear    (flush),
        .din      (in_data),
        .oldest   (oldest)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        if (flush) begin
            state_next = FILL;
        end else begin
            case (state)
                FILL:    if (accept && last_fill) state_next = RUN;
                RUN:     emit = accept;
                default: state_next = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_count <= '0;
        end else if (flush) begin
            fill_count <= '0;
        end else if (accept && (fill_count != CNT_W'(DEPTH))) begin
            fill_count <= fill_count + 1'b1;
        end
    end

    assign diff   = $signed({1'b0, in_data}) - $signed({1'b0, oldest});
    assign scaled = halve ? (diff >>> 1) : diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            primed    <= 1'b0;
        end else begin
            out_valid <= emit;
            primed    <= (state_next == RUN);
            if (emit) begin
                out_data <= OUT_W'(fit_out(32'(scaled), OUT_W));
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_center_derivative_stream.sv
`default_nettype none
// ==========================================================================
// tb_center_derivative_stream : three DUT configurations on one stimulus bus
// Revision: 1.0
// ==========================================================================
module tb_center_derivative_stream;

    localparam int NUM = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic halve = 1'b0;
    logic flush = 1'b0;

    logic ov_a, ov_b, ov_c;
    logic pr_a, pr_b, pr_c;
    logic signed [8:0] od_a;
    logic signed [8:0] od_b;
    logic signed [5:0] od_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    center_derivative_stream #(.DATA_W(8), .STEP(1), .OUT_W(9)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .halve(halve),
        .flush(flush), .out_valid(ov_a), .out_data(od_a), .primed(pr_a));

    center_derivative_stream #(.DATA_W(8), .STEP(2), .OUT_W(9)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .halve(halve),
        .flush(flush), .out_valid(ov_b), .out_data(od_b), .primed(pr_b));

    center_derivative_stream #(.DATA_W(8), .STEP(1), .OUT_W(6)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .halve(halve),
        .flush(flush), .out_valid(ov_c), .out_data(od_c), .primed(pr_c));

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int step_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic int outw_of(input int k);
        return (k == 2) ? 6 : 9;
    endfunction

    function automatic int floor_half(input int d);
        return (d < 0) ? -((1 - d) / 2) : d / 2;
    endfunction

    function automatic int reduce(input int d, input int w);
        int m;
        int half;
        int r;
        m    = 1 << w;
        half = 1 << (w - 1);
`ifdef CENTER_DERIVATIVE_SATURATE_EN
        r = (d > half - 1) ? half - 1 : ((d < -half) ? -half : d);
`else
        r = ((d % m) + m) % m;
        if (r >= half) r = r - m;
`endif
        return r;
    endfunction

    // Model: history of accepted samples since last reset/flush.
    int hist [NUM][$];
    bit exp_valid [NUM];
    int exp_data [NUM];
    bit exp_primed [NUM];
    int model_d;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM; k++) begin
                hist[k].delete();
                exp_valid[k]  = 1'b0;
                exp_data[k]   = 0;
                exp_primed[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM; k++) begin
                exp_valid[k] = 1'b0;
                if (flush) begin
                    hist[k].delete();
                    exp_primed[k] = 1'b0;
                end else if (in_valid) begin
                    if (hist[k].size() == 2 * step_of(k)) begin
                        model_d = int'(in_data) - hist[k][0];
                        if (halve) model_d = floor_half(model_d);
                        exp_valid[k] = 1'b1;
                        exp_data[k]  = reduce(model_d, outw_of(k));
                        void'(hist[k].pop_front());
                    end
                    hist[k].push_back(int'(in_data));
                    exp_primed[k] = (hist[k].size() == 2 * step_of(k));
                end
            end
        end
    end

    always @(negedge clk) begin
        bit av [NUM];
        bit ap [NUM];
        int ad [NUM];
        av = '{ov_a, ov_b, ov_c};
        ap = '{pr_a, pr_b, pr_c};
        ad[0] = int'(od_a);
        ad[1] = int'(od_b);
        ad[2] = int'(od_c);
        for (int k = 0; k < NUM; k++) begin
            check($sformatf("model_out_valid[%0d]", k), int'(av[k]), int'(exp_valid[k]));
            check($sformatf("model_out_data[%0d]", k), ad[k], exp_data[k]);
            check($sformatf("model_primed[%0d]", k), int'(ap[k]), int'(exp_primed[k]));
        end
    end

    task automatic step(input bit v, input int d, input bit h, input bit f);
        @(negedge clk);
        in_valid = v;
        in_data  = 8'(d);
        halve    = h;
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_valid", int'(ov_a), 0);
        check("reset_data", int'(od_a), 0);
        check("reset_primed", int'(pr_a), 0);

        // basic stream
        step(1, 10, 0, 0); check("s1_valid0", int'(ov_a), 0); check("s1_primed0", int'(pr_a), 0);
        step(1, 20, 0, 0); check("s1_valid1", int'(ov_a), 0); check("s1_primed1", int'(pr_a), 1);
        step(1, 40, 0, 0); check("s1_valid2", int'(ov_a), 1); check("s1_data2", int'(od_a), 30);
        step(1, 70, 0, 0); check("s1_valid3", int'(ov_a), 1); check("s1_data3", int'(od_a), 50);
        step(0, 0, 0, 0);  check("s1_strobe", int'(ov_a), 0);

        // halving with floor
        step(0, 0, 0, 1); step(1, 0, 1, 0); step(1, 9, 1, 0); step(1, 3, 1, 0);
        check("s2_half_pos", int'(od_a), 1);
        step(0, 0, 0, 1); step(1, 255, 1, 0); step(1, 9, 1, 0); step(1, 0, 1, 0);
        check("s2_half_neg", int'(od_a), -128);
        step(0, 0, 0, 1); step(1, 0, 1, 0); step(1, 9, 1, 0); step(1, 255, 1, 0);
        check("s2_half_max", int'(od_a), 127);

        // bubbles
        step(0, 0, 0, 1);
        step(1, 5, 0, 0);
        step(0, 0, 0, 0); check("s3_bub0", int'(ov_a), 0);
        step(0, 0, 0, 0); check("s3_bub1", int'(ov_a), 0);
        step(1, 8, 0, 0); check("s3_fill", int'(ov_a), 0);
        step(0, 0, 0, 0); check("s3_bub2", int'(ov_a), 0);
        step(1, 20, 0, 0); check("s3_valid", int'(ov_a), 1); check("s3_data", int'(od_a), 15);
        step(0, 0, 0, 0); check("s3_hold_v", int'(ov_a), 0); check("s3_hold_d", int'(od_a), 15);

        // flush wins over a coincident sample
        check("s4_primed_before", int'(pr_a), 1);
        step(1, 99, 0, 1); check("s4_primed_drop", int'(pr_a), 0); check("s4_no_out", int'(ov_a), 0);
        step(1, 1, 0, 0); check("s4_refill0", int'(ov_a), 0);
        step(1, 2, 0, 0); check("s4_refill1", int'(ov_a), 0);
        step(1, 7, 0, 0); check("s4_valid", int'(ov_a), 1); check("s4_data", int'(od_a), 6);

        // STEP=2 instance
        step(0, 0, 0, 1);
        step(1, 0, 0, 0); step(1, 1, 0, 0);
        step(1, 2, 0, 0); check("s5_primed3", int'(pr_b), 0);
        step(1, 3, 0, 0); check("s5_primed4", int'(pr_b), 1); check("s5_valid4", int'(ov_b), 0);
        step(1, 50, 0, 0); check("s5_valid5", int'(ov_b), 1); check("s5_data5", int'(od_b), 50);

        // narrow output: saturate or wrap
        step(0, 0, 0, 1); step(1, 0, 0, 0); step(1, 5, 0, 0); step(1, 100, 0, 0);
`ifdef CENTER_DERIVATIVE_SATURATE_EN
        check("s6_pos", int'(od_c), 31);
`else
        check("s6_pos", int'(od_c), -28);
`endif
        step(0, 0, 0, 1); step(1, 100, 0, 0); step(1, 5, 0, 0); step(1, 0, 0, 0);
`ifdef CENTER_DERIVATIVE_SATURATE_EN
        check("s6_neg", int'(od_c), -32);
`else
        check("s6_neg", int'(od_c), 28);
`endif
        check("s6_valid_pre_rst", int'(ov_c), 1);

        // async reset mid-cycle clears immediately
        #2 rst = 1'b1;
        #1;
        check("rst_valid_a", int'(ov_a), 0);
        check("rst_data_a", int'(od_a), 0);
        check("rst_primed_a", int'(pr_a), 0);
        check("rst_valid_c", int'(ov_c), 0);
        check("rst_data_c", int'(od_c), 0);
        rst = 1'b0;
        step(1, 1, 0, 0);
        step(1, 2, 0, 0); check("rst_refill", int'(ov_a), 0);
        step(1, 3, 0, 0); check("rst_after_v", int'(ov_a), 1); check("rst_after_d", int'(od_a), 2);
        step(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
